dac_dma_rd: RTL and testbench
=============================

DAC_DMA_RD -- requirements
Module: dac_dma_rd

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, AXI address width; DATA_W, default 128, AXI/AXIS data width; BURST_LEN, default 16, beats per burst; FIFO_DEPTH, default 64, output buffer entries.
REQ-002 SHALL have ports, in order:
- axi_aclk  in  1  single clock.
- axi_rst  in  1  asynchronous active-high reset.
- axi_araddr  out  ADDR_W  burst address.
- axi_arlen  out  8  burst length minus one.
- axi_arsize/arburst/arcache/arprot/arid/aruser  out  3/2/4/3/4/4  constant AR fields.
- axi_arvalid  out  1  AR handshake valid.
- axi_arready  in  1  AR handshake ready.
- axi_rdata  in  DATA_W  read data.
- axi_rresp  in  2  read response.
- axi_rlast  in  1  last beat of burst.
- axi_rvalid  in  1  R handshake valid.
- axi_rready  out  1  R handshake ready.
- axis_tdata  out  DATA_W  DAC sample stream.
- axis_tvalid/axis_tready  out/in  1/1  stream handshake.
- axis_tlast  out  1  last beat of one pass.
- read_start  in  1  one-cycle start pulse.
- read_reset  in  1  one-cycle abort pulse.
- start_address  in  32  buffer base; bits[7:0] ignored.
- play_size  in  32  bytes per pass; bits[7:0] ignored.
- loop_en  in  1  repeat passes.
- current_addr  out  32  address of last accepted AR.
- run_cycles  out  8  completed passes.
- rd_err  out  1  sticky response error.
- play_done  out  1  pass sequence finished.

Function
REQ-003 AR constants SHALL be: arlen=BURST_LEN-1, arsize=3'b100, arburst=INCR, arcache=4'b0011, arprot=0, arid=0, aruser=0.
REQ-004 Start address and size SHALL be latched on read_start in IDLE; read_start outside IDLE SHALL be ignored.
REQ-005 Bursts per pass SHALL be play_size[31:8]; a value of 0 SHALL leave the FSM in IDLE with no outputs changed.
REQ-006 States SHALL be IDLE, REQ, DRAIN, ABORT.
- IDLE -> REQ on accepted start.
- REQ -> DRAIN after the final AR of a non-looping pass.
- DRAIN -> IDLE when no burst is outstanding and the FIFO is empty.
- Any non-IDLE state -> ABORT on read_reset.
REQ-007 A credit counter SHALL track free FIFO entries minus outstanding beats.
- arvalid asserts only in REQ and only when credit >= BURST_LEN.
- Credit is decremented by BURST_LEN at AR handshake and incremented by 1 at each AXIS handshake.
REQ-008 arvalid/araddr SHALL remain stable until arready; the address SHALL advance by BURST_LEN*16 bytes per handshake.
REQ-009 axi_rready SHALL be constantly 1 outside reset; credit guarantees space. The R-beat to FIFO write latency SHALL be 1 cycle.
REQ-010 The AXIS output SHALL be fed from the FIFO in first-in first-out order, with no bubble when tready is held high and data is available.
REQ-011 axis_tlast SHALL assert on the final beat of every pass, counted at FIFO write and stored alongside the data.
REQ-012 Any R beat with rresp != 2'b00 SHALL set rd_err, which stays set until read_start or reset; data SHALL still be forwarded.
REQ-013 run_cycles SHALL increment, saturating at 255, on the AXIS handshake of each tlast beat; it SHALL clear on an accepted read_start.
REQ-014 play_done SHALL go to 1 on the DRAIN->IDLE transition and clear on an accepted read_start.
REQ-015 ABORT SHALL stop issuing AR, keep rready=1, discard returning beats, flush the FIFO and hold tvalid=0. It SHALL return to IDLE once outstanding bursts reach 0, without setting play_done.
REQ-016 When read_start and read_reset arrive in the same cycle, read_reset SHALL take priority.

Reset
REQ-017 On axi_rst: state=IDLE; all outputs except constants = 0; credit = FIFO_DEPTH; FIFO empty.

Configuration
REQ-018 Loop mode SHALL be compiled under DAC_DMA_RD_LOOP_EN.
- Defined: with loop_en=1, REQ wraps to the latched start address after the final AR of a pass and stays in REQ until read_reset.
- Undefined: loop_en is ignored and each start plays exactly one pass.

Structure
REQ-019 A shared package dac_dma_pkg SHALL hold the state enum, AXI burst/size/cache constants and BURST_LEN/FIFO_DEPTH defaults.
REQ-020 The FIFO SHALL be a sub-module dac_dma_fifo: synchronous, DATA_W+1 wide, FIFO_DEPTH deep, with registered output and a flush input.

Verification
REQ-021 start_address=0x1000_0000, play_size=0x400, tready=1 -> 4 ARs at 0x1000_0000/100/200/300, 64 beats out, tlast on beat 64, play_done=1, run_cycles=1.
REQ-022 Same stimulus, tready=0 -> at most 4 ARs issued (64-entry credit); arvalid=0 thereafter until tready resumes; no data lost.
REQ-023 play_size=0x1FF -> one burst, 16 beats; play_size=0x0FF -> stays IDLE, no AR.
REQ-024 rresp=2'b10 on beat 5 -> rd_err=1, all 16 beats still output.
REQ-025 read_reset with 2 bursts outstanding -> no further AR, 32 beats absorbed, tvalid=0, back to IDLE, play_done=0.
REQ-026 With DAC_DMA_RD_LOOP_EN defined, loop_en=1, play_size=0x200 -> addresses wrap base, base+0x100, base, ...; run_cycles=3 after 3 tlasts.

Source files
------------

// File: rtl/dac_dma_pkg.sv
// Shared types and AXI constants for the DAC DMA read engine.
// No logic; the FSM encoding and default sizing live here.
// Backpressure: n/a.
package dac_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRAIN,
    ST_ABORT
  } state_t;

  localparam int BURST_LEN_DEF  = 16;
  localparam int FIFO_DEPTH_DEF = 64;
  localparam int BEAT_BYTES     = 16;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;

endpackage

// File: rtl/dac_dma_fifo.sv
// Synchronous FIFO with a registered output stage and a synchronous flush.
// Latency: write to rd_vld is 2 cycles; back-to-back pops stream without bubbles.
// Backpressure: rd_rdy low holds the output register; writer must respect external credit.
module dac_dma_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             pop, load;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop   = rd_vld && rd_rdy;
  // Refill the output register whenever it is free or being consumed this cycle.
  assign load  = (cnt != '0) && (!rd_vld || pop);
  assign empty = (cnt == '0) && !rd_vld;

  always_ff @(posedge clk) begin
    if (wr_vld && !flush) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rd_vld <= 1'b0;
      rd_dat <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rd_vld <= 1'b0;
    end else begin
      if (wr_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (load) begin
        rd_ptr <= ptr_inc(rd_ptr);
        rd_dat <= mem[rd_ptr];
        rd_vld <= 1'b1;
      end else if (pop) begin
        rd_vld <= 1'b0;
      end
      cnt <= cnt + CNT_W'(wr_vld) - CNT_W'(load);
    end
  end

endmodule

// File: rtl/dac_dma_rd.sv
// AXI4 burst reader feeding a DAC AXIS stream; DAC_DMA_RD_LOOP_EN builds the repeat-pass mode.
// Latency: R beat to FIFO write 1 cycle, FIFO write to tvalid 2 cycles.
// Backpressure: ARs are issued only against FIFO credit, so rready stays high and tready stalls reads.
module dac_dma_rd
  import dac_dma_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              axi_aclk,
  input  logic              axi_rst,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic [3:0]        axi_arcache,
  output logic [2:0]        axi_arprot,
  output logic [3:0]        axi_arid,
  output logic [3:0]        axi_aruser,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [DATA_W-1:0] axis_tdata,
  output logic              axis_tvalid,
  input  logic              axis_tready,
  output logic              axis_tlast,
  input  logic              read_start,
  input  logic              read_reset,
  input  logic [31:0]       start_address,
  input  logic [31:0]       play_size,
  input  logic              loop_en,
  output logic [31:0]       current_addr,
  output logic [7:0]        run_cycles,
  output logic              rd_err,
  output logic              play_done
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [CRED_W-1:0] CRED_FULL  = CRED_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0] CRED_BURST = CRED_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN * BEAT_BYTES);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_addr;
  logic [23:0]         n_bursts, ar_cnt, r_burst;
  logic [CRED_W-1:0]   credit, outstanding;
  logic                rready_q;
  logic                r_vld_q, r_last_q;
  logic [DATA_W-1:0]   r_dat_q;
  logic                start_ok, ar_hs, r_hs, axis_hs, last_ar, pass_wrap;
  logic                fifo_flush, fifo_wr, fifo_vld, fifo_rdy, fifo_empty;
  logic [DATA_W:0]     fifo_dat;
  logic                unused_bits;

  assign axi_arlen   = 8'(BURST_LEN - 1);
  assign axi_arsize  = AXI_SIZE_16B;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arcache = AXI_CACHE_MOD;
  assign axi_arprot  = 3'b000;
  assign axi_arid    = 4'b0000;
  assign axi_aruser  = 4'b0000;
  assign axi_rready  = rready_q;

  // A zero-burst pass is not a start at all: nothing is latched or cleared.
  assign start_ok = (state == ST_IDLE) && read_start && !read_reset && (play_size[31:8] != 24'd0);
  assign ar_hs    = axi_arvalid && axi_arready;
  assign r_hs     = axi_rvalid && rready_q;
  assign axis_hs  = axis_tvalid && axis_tready;
  assign last_ar  = (ar_cnt == n_bursts - 24'd1);

`ifdef DAC_DMA_RD_LOOP_EN
  logic loop_q;
  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst)       loop_q <= 1'b0;
    else if (start_ok) loop_q <= loop_en;
  end
  assign pass_wrap   = loop_q;
  assign unused_bits = ^{start_address[7:0], play_size[7:0]};
`else
  assign pass_wrap   = 1'b0;
  assign unused_bits = ^{start_address[7:0], play_size[7:0], loop_en};
`endif

  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    axi_arvalid = 1'b0;
    fifo_flush  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        axi_arvalid = (credit >= CRED_BURST);
        if (read_reset)                          state_nxt = ST_ABORT;
        else if (ar_hs && last_ar && !pass_wrap) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (read_reset) state_nxt = ST_ABORT;
        else if (outstanding == '0 && fifo_empty && !r_vld_q) state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        fifo_flush = 1'b1;
        if (outstanding == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      rready_q     <= 1'b0;
      base_addr    <= '0;
      axi_araddr   <= '0;
      n_bursts     <= '0;
      ar_cnt       <= '0;
      r_burst      <= '0;
      credit       <= CRED_FULL;
      outstanding  <= '0;
      r_vld_q      <= 1'b0;
      r_last_q     <= 1'b0;
      r_dat_q      <= '0;
      current_addr <= '0;
      run_cycles   <= '0;
      rd_err       <= 1'b0;
      play_done    <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      if (start_ok) begin
        base_addr  <= ADDR_W'({start_address[31:8], 8'h00});
        axi_araddr <= ADDR_W'({start_address[31:8], 8'h00});
        n_bursts   <= play_size[31:8];
        ar_cnt     <= '0;
        r_burst    <= '0;
        rd_err     <= 1'b0;
        run_cycles <= '0;
        play_done  <= 1'b0;
      end
      if (ar_hs) begin
        current_addr <= 32'(axi_araddr);
        if (last_ar) begin
          ar_cnt <= '0;
          if (pass_wrap) axi_araddr <= base_addr;
        end else begin
          ar_cnt     <= ar_cnt + 24'd1;
          axi_araddr <= axi_araddr + ADDR_STEP;
        end
      end
      if (r_hs && axi_rresp != 2'b00) rd_err <= 1'b1;
      if (r_hs && axi_rlast) r_burst <= (r_burst == n_bursts - 24'd1) ? 24'd0 : r_burst + 24'd1;
      // Pass end is tagged here so tlast travels with its data through the FIFO.
      r_vld_q  <= r_hs && (state != ST_ABORT);
      r_dat_q  <= axi_rdata;
      r_last_q <= axi_rlast && (r_burst == n_bursts - 24'd1);
      if (axis_hs && axis_tlast && run_cycles != 8'hFF) run_cycles <= run_cycles + 8'd1;
      if (state == ST_DRAIN && state_nxt == ST_IDLE) play_done <= 1'b1;
      outstanding <= outstanding + CRED_W'(ar_hs) - CRED_W'(r_hs && axi_rlast);
      // Everything in flight during abort is discarded, so the whole buffer is free again.
      if (state == ST_ABORT) credit <= CRED_FULL;
      else credit <= credit + CRED_W'(axis_hs) - (ar_hs ? CRED_BURST : '0);
    end
  end

  assign fifo_wr  = r_vld_q && (state != ST_ABORT);
  assign fifo_rdy = axis_tready && (state != ST_ABORT);

  dac_dma_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (axi_aclk),
    .rst    (axi_rst),
    .flush  (fifo_flush),
    .wr_vld (fifo_wr),
    .wr_dat ({r_last_q, r_dat_q}),
    .rd_vld (fifo_vld),
    .rd_rdy (fifo_rdy),
    .rd_dat (fifo_dat),
    .empty  (fifo_empty)
  );

  assign axis_tvalid = fifo_vld && (state != ST_ABORT);
  assign axis_tdata  = fifo_dat[DATA_W-1:0];
  assign axis_tlast  = axis_tvalid && fifo_dat[DATA_W];

endmodule

// File: tb/tb_dac_dma_rd.sv
// Directed bench for dac_dma_rd: AXI read slave model plus an AXIS sink checking data/tlast order.
`timescale 1ns/1ps
module tb_dac_dma_rd;

  logic         axi_aclk = 1'b0;
  logic         axi_rst;
  logic [31:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic [2:0]   axi_arsize;
  logic [1:0]   axi_arburst;
  logic [3:0]   axi_arcache;
  logic [2:0]   axi_arprot;
  logic [3:0]   axi_arid;
  logic [3:0]   axi_aruser;
  logic         axi_arvalid;
  logic         axi_arready;
  logic [127:0] axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast;
  logic         axi_rvalid;
  logic         axi_rready;
  logic [127:0] axis_tdata;
  logic         axis_tvalid;
  logic         axis_tready;
  logic         axis_tlast;
  logic         read_start;
  logic         read_reset;
  logic [31:0]  start_address;
  logic [31:0]  play_size;
  logic         loop_en;
  logic [31:0]  current_addr;
  logic [7:0]   run_cycles;
  logic         rd_err;
  logic         play_done;

  always #5 axi_aclk = ~axi_aclk;

  dac_dma_rd #(
    .ADDR_W(32), .DATA_W(128), .BURST_LEN(16), .FIFO_DEPTH(64)
  ) dut (
    .axi_aclk(axi_aclk), .axi_rst(axi_rst),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arid(axi_arid), .axi_aruser(axi_aruser),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
    .axis_tlast(axis_tlast),
    .read_start(read_start), .read_reset(read_reset),
    .start_address(start_address), .play_size(play_size), .loop_en(loop_en),
    .current_addr(current_addr), .run_cycles(run_cycles), .rd_err(rd_err),
    .play_done(play_done)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // AXI read slave: data of each beat is its own byte address.
  logic [31:0] ar_q[$];
  logic [31:0] ar_log[$];
  int          ar_limit = 1000;
  bit          r_en     = 1'b1;
  int          r_beats  = 0;
  int          err_at   = -1;
  logic [31:0] cur_addr = '0;
  int          beat_idx = 0;
  bit          have     = 1'b0;
  bit          s_ar_hs, s_r_hs;
  logic [31:0] s_addr;

  always @(negedge axi_aclk) begin
    s_ar_hs = axi_arvalid && axi_arready;
    s_r_hs  = axi_rvalid && axi_rready;
    s_addr  = axi_araddr;
    @(posedge axi_aclk);
    #1;
    if (s_ar_hs) begin
      ar_q.push_back(s_addr);
      ar_log.push_back(s_addr);
    end
    if (s_r_hs) begin
      r_beats++;
      if (beat_idx == 15) have = 1'b0;
      else beat_idx++;
    end
    if (!have && ar_q.size() > 0) begin
      cur_addr = ar_q.pop_front();
      beat_idx = 0;
      have     = 1'b1;
    end
    axi_arready = (ar_log.size() < ar_limit);
    axi_rvalid  = have && r_en;
    axi_rdata   = 128'(cur_addr + 32'(beat_idx) * 32'd16);
    axi_rlast   = (beat_idx == 15);
    axi_rresp   = (r_beats == err_at) ? 2'b10 : 2'b00;
  end

  // AXIS sink: beat n of a pass must carry base + (n mod pass)*16.
  int          out_beats  = 0;
  int          data_errs  = 0;
  int          tlast_errs = 0;
  int          tlast_cnt  = 0;
  int          pass_beats = 1;
  logic [31:0] exp_base   = '0;
  int          m_pos;
  logic [127:0] m_exp;

  always @(negedge axi_aclk) begin
    if (axis_tvalid && axis_tready) begin
      m_pos = out_beats % pass_beats;
      m_exp = 128'(exp_base + 32'(m_pos) * 32'd16);
      if (axis_tdata !== m_exp) data_errs++;
      if (axis_tlast !== (m_pos == pass_beats - 1)) tlast_errs++;
      if (axis_tlast) tlast_cnt++;
      out_beats++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge axi_aclk);
    #1;
  endtask

  task automatic start_pass(input logic [31:0] addr, input logic [31:0] size, input int beats);
    ar_log.delete();
    out_beats  = 0;
    data_errs  = 0;
    tlast_errs = 0;
    tlast_cnt  = 0;
    r_beats    = 0;
    exp_base   = {addr[31:8], 8'h00};
    pass_beats = (beats > 0) ? beats : 1;
    start_address = addr;
    play_size     = size;
    @(posedge axi_aclk); #1 read_start = 1'b1;
    @(posedge axi_aclk); #1 read_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (play_done !== 1'b1 && n < max) begin
      @(posedge axi_aclk); #1;
      n++;
    end
    check(tag, 64'(play_done), 64'd1);
  endtask

  function automatic logic [31:0] ar_at(input int i);
    return (ar_log.size() > i) ? ar_log[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_rst = 1'b1; read_start = 1'b0; read_reset = 1'b0;
    start_address = '0; play_size = '0; loop_en = 1'b0;
    axis_tready = 1'b1; axi_arready = 1'b1; axi_rvalid = 1'b0;
    axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b0;
    tick(3);
    check("rst_arvalid", 64'(axi_arvalid), 64'd0);
    check("rst_araddr", 64'(axi_araddr), 64'd0);
    check("rst_rready", 64'(axi_rready), 64'd0);
    check("rst_tvalid", 64'(axis_tvalid), 64'd0);
    check("rst_run_cycles", 64'(run_cycles), 64'd0);
    check("rst_flags", 64'({rd_err, play_done}), 64'd0);
    check("rst_current_addr", 64'(current_addr), 64'd0);
    check("ar_consts", 64'({axi_arlen, axi_arsize, axi_arburst, axi_arcache, axi_arprot, axi_arid, axi_aruser}),
          64'({8'd15, 3'b100, 2'b01, 4'b0011, 3'b000, 4'h0, 4'h0}));
    axi_rst = 1'b0;
    tick(2);
    check("rready_on", 64'(axi_rready), 64'd1);

    // Four-burst pass streaming freely.
    start_pass(32'h1000_0000, 32'h400, 64);
    wait_done("t1_done", 2000);
    check("t1_ar_count", 64'(ar_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("t1_araddr", 64'(ar_at(i)), 64'(32'h1000_0000 + 32'(i) * 32'h100));
    check("t1_beats", 64'(out_beats), 64'd64);
    check("t1_data_errs", 64'(data_errs), 64'd0);
    check("t1_tlast_errs", 64'(tlast_errs), 64'd0);
    check("t1_tlast_cnt", 64'(tlast_cnt), 64'd1);
    check("t1_run_cycles", 64'(run_cycles), 64'd1);
    check("t1_current_addr", 64'(current_addr), 64'h1000_0300);
    check("t1_rd_err", 64'(rd_err), 64'd0);

    // Same pass with the sink stalled: credit caps ARs at the FIFO depth.
    axis_tready = 1'b0;
    start_pass(32'h1000_0000, 32'h400, 64);
    tick(200);
    check("t2_ar_count_stall", 64'(ar_log.size()), 64'd4);
    check("t2_arvalid_stall", 64'(axi_arvalid), 64'd0);
    check("t2_beats_stall", 64'(out_beats), 64'd0);
    check("t2_r_beats_stall", 64'(r_beats), 64'd64);
    check("t2_done_cleared", 64'(play_done), 64'd0);
    check("t2_tvalid_stall", 64'(axis_tvalid), 64'd1);
    axis_tready = 1'b1;
    wait_done("t2_done", 2000);
    check("t2_beats", 64'(out_beats), 64'd64);
    check("t2_data_errs", 64'(data_errs), 64'd0);
    check("t2_tlast_errs", 64'(tlast_errs), 64'd0);
    check("t2_run_cycles", 64'(run_cycles), 64'd1);

    // Sub-burst size rounds down to one burst; low address bits are ignored.
    start_pass(32'h2000_00AB, 32'h1FF, 16);
    wait_done("t3_done", 1000);
    check("t3_ar_count", 64'(ar_log.size()), 64'd1);
    check("t3_araddr", 64'(ar_at(0)), 64'h2000_0000);
    check("t3_beats", 64'(out_beats), 64'd16);
    check("t3_data_errs", 64'(data_errs), 64'd0);
    check("t3_tlast_cnt", 64'(tlast_cnt), 64'd1);

    // Zero bursts: start is not taken and nothing changes.
    start_pass(32'h3000_0000, 32'h0FF, 16);
    tick(40);
    check("t3z_ar_count", 64'(ar_log.size()), 64'd0);
    check("t3z_play_done", 64'(play_done), 64'd1);
    check("t3z_run_cycles", 64'(run_cycles), 64'd1);
    check("t3z_current_addr", 64'(current_addr), 64'h2000_0000);

    // Error response on the fifth beat: flagged, data still delivered.
    err_at = 4;
    start_pass(32'h4000_0000, 32'h100, 16);
    wait_done("t4_done", 1000);
    err_at = -1;
    check("t4_rd_err", 64'(rd_err), 64'd1);
    check("t4_beats", 64'(out_beats), 64'd16);
    check("t4_data_errs", 64'(data_errs), 64'd0);

    // Start and abort together in IDLE: abort wins, start ignored.
    ar_log.delete();
    start_address = 32'h5000_0000;
    play_size     = 32'h100;
    @(posedge axi_aclk); #1 read_start = 1'b1; read_reset = 1'b1;
    @(posedge axi_aclk); #1 read_start = 1'b0; read_reset = 1'b0;
    tick(30);
    check("t5_ar_count", 64'(ar_log.size()), 64'd0);
    check("t5_rd_err_kept", 64'(rd_err), 64'd1);

    // Abort with two bursts outstanding.
    r_en = 1'b0;
    ar_limit = 2;
    start_pass(32'h6000_0000, 32'h400, 64);
    for (int n = 0; n < 100 && ar_log.size() < 2; n++) tick(1);
    check("t6_ar_before", 64'(ar_log.size()), 64'd2);
    check("t6_rd_err_cleared", 64'(rd_err), 64'd0);
    @(posedge axi_aclk); #1 read_reset = 1'b1;
    @(posedge axi_aclk); #1 read_reset = 1'b0;
    ar_limit = 1000;
    tick(20);
    check("t6_ar_after", 64'(ar_log.size()), 64'd2);
    check("t6_arvalid", 64'(axi_arvalid), 64'd0);
    r_en = 1'b1;
    tick(80);
    check("t6_r_absorbed", 64'(r_beats), 64'd32);
    check("t6_beats_out", 64'(out_beats), 64'd0);
    check("t6_tvalid", 64'(axis_tvalid), 64'd0);
    check("t6_play_done", 64'(play_done), 64'd0);
    start_pass(32'h7000_0000, 32'h100, 16);
    wait_done("t6_restart_done", 1000);
    check("t6_restart_beats", 64'(out_beats), 64'd16);
    check("t6_restart_data", 64'(data_errs), 64'd0);

    // Loop request: repeats only when the loop feature is built.
    loop_en = 1'b1;
    start_pass(32'h8000_0000, 32'h200, 32);
`ifdef DAC_DMA_RD_LOOP_EN
    for (int n = 0; n < 2000 && out_beats < 96; n++) tick(1);
    tick(1);
    check("t7_run_cycles", 64'(run_cycles), 64'd3);
    check("t7_addr0", 64'(ar_at(0)), 64'h8000_0000);
    check("t7_addr1", 64'(ar_at(1)), 64'h8000_0100);
    check("t7_addr2", 64'(ar_at(2)), 64'h8000_0000);
    check("t7_addr3", 64'(ar_at(3)), 64'h8000_0100);
    check("t7_data_errs", 64'(data_errs), 64'd0);
    check("t7_tlast_errs", 64'(tlast_errs), 64'd0);
    @(posedge axi_aclk); #1 read_reset = 1'b1;
    @(posedge axi_aclk); #1 read_reset = 1'b0;
    tick(100);
    check("t7_arvalid_stop", 64'(axi_arvalid), 64'd0);
    check("t7_play_done", 64'(play_done), 64'd0);
`else
    wait_done("t7_done", 1000);
    check("t7_ar_count", 64'(ar_log.size()), 64'd2);
    check("t7_run_cycles", 64'(run_cycles), 64'd1);
    check("t7_beats", 64'(out_beats), 64'd32);
    check("t7_tlast_cnt", 64'(tlast_cnt), 64'd1);
`endif
    loop_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
